// File: rtl/vga_pkg.sv
// Shared definitions for the VGA frame scheduler: default timing, FSM states,
// config register addresses and the four-register configuration set.
package vga_pkg;

  localparam int POS_W         = 10;
  localparam int H_DISPLAY_DEF = 640;
  localparam int H_MAX_DEF     = 799;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_MAX_DEF     = 524;

  typedef enum logic [1:0] {
    ST_OPEN   = 2'd0,
    ST_ARMED  = 2'd1,
    ST_COMMIT = 2'd2
  } vga_state_t;

  typedef enum logic [1:0] {
    ADDR_SCROLL_X = 2'd0,
    ADDR_SCROLL_Y = 2'd1,
    ADDR_MODE     = 2'd2,
    ADDR_EFFECT   = 2'd3
  } cfg_addr_t;

  typedef struct packed {
    logic [POS_W-1:0] scroll_x;
    logic [POS_W-1:0] scroll_y;
    logic [3:0]       mode;
    logic [3:0]       effect;
  } cfg_set_t;

  typedef struct packed {
    vga_state_t state;
    logic       visible;
  } vga_dbg_t;

  // Mode and effect are 4-bit fields; the upper data bits are dropped for them.
  function automatic cfg_set_t apply_write(cfg_set_t cur, cfg_addr_t addr,
                                           logic [POS_W-1:0] data);
    cfg_set_t nxt;
    nxt = cur;
    case (addr)
      ADDR_SCROLL_X: nxt.scroll_x = data;
      ADDR_SCROLL_Y: nxt.scroll_y = data;
      ADDR_MODE:     nxt.mode     = data[3:0];
      ADDR_EFFECT:   nxt.effect   = data[3:0];
      default:       nxt          = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/vga_frame_scheduler_if.sv
// Config write / commit port of the frame scheduler.
// Handshake: a write transfers on every clock where cfg_valid and cfg_ready are
// both high; commit_req is a single-cycle pulse with no handshake of its own.
interface vga_frame_scheduler_if;

  logic       cfg_valid;
  logic       cfg_ready;
  logic [1:0] cfg_addr;
  logic [9:0] cfg_data;
  logic       commit_req;

  modport master (
    output cfg_valid,
    output cfg_addr,
    output cfg_data,
    output commit_req,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid,
    input  cfg_addr,
    input  cfg_data,
    input  commit_req,
    output cfg_ready
  );

endinterface

// File: rtl/vga_cfg_regs.sv
// Shadow / active register pair: writes land in shadow, commit copies the whole
// shadow set into active in one clock so the display never sees a partial update.
module vga_cfg_regs
  import vga_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  cfg_addr_t        wr_addr,
  input  logic [POS_W-1:0] wr_data,
  input  logic             commit,
  output cfg_set_t         active
);

  cfg_set_t shadow_q;
  cfg_set_t active_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shadow_q <= '0;
      active_q <= '0;
    end else begin
      if (wr_en) begin
        shadow_q <= apply_write(shadow_q, wr_addr, wr_data);
      end
      if (commit) begin
        active_q <= shadow_q;
      end
    end
  end

  assign active = active_q;

endmodule

// File: rtl/vga_frame_scheduler.sv
// Frame scheduler: line/frame strobes and frame counter from the beam position,
// plus an OPEN/ARMED/COMMIT FSM that applies shadow config at vblank entry.
module vga_frame_scheduler
  import vga_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_MAX     = H_MAX_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_MAX     = V_MAX_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [POS_W-1:0]      hpos,
  input  logic [POS_W-1:0]      vpos,
  vga_frame_scheduler_if.slave  cfg,
  output logic [POS_W-1:0]      scroll_x,
  output logic [POS_W-1:0]      scroll_y,
  output logic [3:0]            mode,
  output logic [3:0]            effect,
  output logic                  frame_start,
  output logic                  line_start,
  output logic                  vblank,
  output logic [7:0]            frame_count,
  output logic                  armed,
  output vga_dbg_t              dbg
);

  localparam logic [POS_W-1:0] H_DISPLAY_P = POS_W'(H_DISPLAY);
  localparam logic [POS_W-1:0] H_MAX_P     = POS_W'(H_MAX);
  localparam logic [POS_W-1:0] V_DISPLAY_P = POS_W'(V_DISPLAY);
  localparam logic [POS_W-1:0] V_MAX_P     = POS_W'(V_MAX);

  // Beam-position decode; positions beyond the frame never produce events.
  logic in_range;
  logic at_line;
  logic at_frame;
  logic at_entry;

  assign in_range = (hpos <= H_MAX_P) && (vpos <= V_MAX_P);
  assign at_line  = in_range && (hpos == '0);
  assign at_frame = at_line && (vpos == '0);
  assign at_entry = at_line && (vpos == V_DISPLAY_P);

  vga_state_t state_q;
  vga_state_t state_d;
  logic       commit;
  logic       ready;
  logic       wr_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_OPEN;
    end else begin
      state_q <= state_d;
    end
  end

  // The active set is loaded on the same edge that enters COMMIT, so the new
  // values appear one cycle after the vblank-entry sample.
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    case (state_q)
      ST_OPEN: begin
        if (cfg.commit_req) begin
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (at_entry) begin
          state_d = ST_COMMIT;
          commit  = 1'b1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_OPEN;
      end
      default: begin
        state_d = ST_OPEN;
      end
    endcase
  end

  assign ready         = (state_q == ST_OPEN);
  assign wr_en         = cfg.cfg_valid && ready;
  assign cfg.cfg_ready = ready;
  assign armed         = (state_q != ST_OPEN);

  logic visible_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      vblank      <= 1'b0;
      frame_count <= '0;
      visible_q   <= 1'b0;
    end else begin
      line_start  <= at_line;
      frame_start <= at_frame;
      vblank      <= (vpos >= V_DISPLAY_P);
      visible_q   <= (hpos < H_DISPLAY_P) && (vpos < V_DISPLAY_P);
      if (at_frame) begin
        frame_count <= frame_count + 8'd1;
      end
    end
  end

  cfg_set_t active;

  vga_cfg_regs u_cfg_regs (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (cfg_addr_t'(cfg.cfg_addr)),
    .wr_data (cfg.cfg_data),
    .commit  (commit),
    .active  (active)
  );

  assign scroll_x = active.scroll_x;
  assign scroll_y = active.scroll_y;
  assign mode     = active.mode;
  assign effect   = active.effect;

  assign dbg.state   = state_q;
  assign dbg.visible = visible_q;

endmodule

// File: tb/tb_vga_frame_scheduler.sv
// Bench for vga_frame_scheduler on a shrunken 12x10 frame: directed scenarios
// feed an expected queue per sample and a commit queue; a negedge monitor checks.
module tb_vga_frame_scheduler;
  import vga_pkg::*;

  localparam int HD    = 8;
  localparam int HM    = 11;
  localparam int VD    = 6;
  localparam int VM    = 9;
  localparam int FRAME = (HM + 1) * (VM + 1);

  localparam logic [9:0] HD_P = 10'(HD);
  localparam logic [9:0] HM_P = 10'(HM);
  localparam logic [9:0] VD_P = 10'(VD);
  localparam logic [9:0] VM_P = 10'(VM);

  // clock / reset
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [9:0] hpos = '0;
  logic [9:0] vpos = '0;
  logic [9:0] scroll_x;
  logic [9:0] scroll_y;
  logic [3:0] mode;
  logic [3:0] effect;
  logic       frame_start;
  logic       line_start;
  logic       vblank;
  logic [7:0] frame_count;
  logic       armed;
  vga_dbg_t   dbg;

  vga_frame_scheduler_if cfg_if ();

  vga_frame_scheduler #(
    .H_DISPLAY (HD),
    .H_MAX     (HM),
    .V_DISPLAY (VD),
    .V_MAX     (VM)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .hpos        (hpos),
    .vpos        (vpos),
    .cfg         (cfg_if.slave),
    .scroll_x    (scroll_x),
    .scroll_y    (scroll_y),
    .mode        (mode),
    .effect      (effect),
    .frame_start (frame_start),
    .line_start  (line_start),
    .vblank      (vblank),
    .frame_count (frame_count),
    .armed       (armed),
    .dbg         (dbg)
  );

  // scoreboard state
  int          checks = 0;
  int          errors = 0;
  logic [11:0] exp_q[$];
  logic [63:0] cmt_q[$];
  logic [7:0]  fc_exp = '0;
  int          gen_frame = 0;
  logic [9:0]  last_h = '0;
  logic [9:0]  last_v = '0;
  int          last_f = 0;
  logic [27:0] prev_active = '0;
  logic [27:0] mon_active;
  logic [11:0] mon_e;
  int          lines_in_frame = 0;
  bit          frame_seen = 1'b0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // driver tasks: every clock after reset goes through tick()
  task automatic tick();
    logic in_rng;
    logic ls;
    logic fs;
    @(posedge clk);
    last_h = hpos;
    last_v = vpos;
    last_f = gen_frame;
    in_rng = (hpos <= HM_P) && (vpos <= VM_P);
    ls     = in_rng && (hpos == 10'd0);
    fs     = ls && (vpos == 10'd0);
    if (fs) fc_exp = fc_exp + 8'd1;
    exp_q.push_back({(hpos < HD_P) && (vpos < VD_P), fs, ls, (vpos >= VD_P), fc_exp});
    #1;
  endtask

  task automatic advance();
    if (hpos == HM_P) begin
      hpos = 10'd0;
      if (vpos == VM_P) begin
        vpos = 10'd0;
        gen_frame++;
      end else begin
        vpos = vpos + 10'd1;
      end
    end else begin
      hpos = hpos + 10'd1;
    end
  endtask

  task automatic step();
    tick();
    advance();
  endtask

  task automatic goto_pos(logic [9:0] v, logic [9:0] h);
    int n;
    n = 0;
    while (!(hpos == h && vpos == v) && n < 2 * FRAME) begin
      step();
      n++;
    end
  endtask

  task automatic oor(logic [9:0] h, logic [9:0] v);
    logic [9:0] sh;
    logic [9:0] sv;
    sh   = hpos;
    sv   = vpos;
    hpos = h;
    vpos = v;
    tick();
    hpos = sh;
    vpos = sv;
  endtask

  task automatic drive_write(logic [1:0] a, logic [9:0] d);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = a;
    cfg_if.cfg_data  = d;
    chk("cfg_ready_open", 64'(cfg_if.cfg_ready), 64'(1));
    step();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic arm();
    cfg_if.commit_req = 1'b1;
    step();
    cfg_if.commit_req = 1'b0;
    chk("armed_after_req", 64'(armed), 64'(1));
  endtask

  // Frame whose vblank-entry sample is still ahead of the driven position.
  function automatic int entry_frame();
    if (vpos < VD_P || (vpos == VD_P && hpos == 10'd0)) return gen_frame;
    return gen_frame + 1;
  endfunction

  task automatic push_commit(logic [9:0] sx, logic [9:0] sy, logic [3:0] md,
                             logic [3:0] ef, int frame);
    cmt_q.push_back({sx, sy, md, ef, 16'(frame), VD_P, 10'd0});
  endtask

  // monitor
  always @(negedge clk) begin
    if (reset) begin
      frame_seen     = 1'b0;
      lines_in_frame = 0;
      prev_active    = {scroll_x, scroll_y, mode, effect};
    end else begin
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("strobes", 64'({dbg.visible, frame_start, line_start, vblank, frame_count}),
            64'(mon_e));
        if (frame_start) begin
          if (frame_seen) chk("lines_per_frame", 64'(lines_in_frame), 64'(VM + 1));
          frame_seen     = 1'b1;
          lines_in_frame = 0;
        end
        if (line_start) lines_in_frame++;
      end
      mon_active = {scroll_x, scroll_y, mode, effect};
      if (dbg.state == ST_COMMIT || mon_active != prev_active) begin
        if (cmt_q.size() == 0) begin
          chk("unexpected_commit", 64'({dbg.state == ST_COMMIT, mon_active}),
              64'({1'b0, prev_active}));
        end else begin
          chk("commit", {mon_active, 16'(last_f), last_v, last_h}, cmt_q.pop_front());
        end
      end
      prev_active = mon_active;
    end
  end

  initial begin
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_addr   = 2'd0;
    cfg_if.cfg_data   = 10'd0;
    cfg_if.commit_req = 1'b0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({scroll_x, scroll_y, mode, effect, frame_start, line_start,
                              vblank, frame_count, armed}), 64'(0));
    chk("reset_ready", 64'(cfg_if.cfg_ready), 64'(1));
    chk("reset_state", 64'(dbg.state), 64'(ST_OPEN));
    reset = 1'b0;

    // commit of scroll_x at mid-frame lands right after vblank entry
    drive_write(ADDR_SCROLL_X, 10'd37);
    goto_pos(10'd2, 10'd3);
    arm();
    push_commit(10'd37, 10'd0, 4'd0, 4'd0, entry_frame());
    goto_pos(VD_P, 10'd0);
    chk("sx_before_entry", 64'(scroll_x), 64'(0));
    chk("armed_before_entry", 64'(armed), 64'(1));
    step();
    chk("sx_at_commit", 64'(scroll_x), 64'(37));
    chk("armed_in_commit", 64'(armed), 64'(1));
    step();
    chk("armed_dropped", 64'(armed), 64'(0));
    chk("ready_back", 64'(cfg_if.cfg_ready), 64'(1));

    // write held during ARMED is blocked until the FSM reopens
    arm();
    push_commit(10'd37, 10'd0, 4'd0, 4'd0, entry_frame());
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_addr  = ADDR_SCROLL_Y;
    cfg_if.cfg_data  = 10'd5;
    step();
    chk("ready_armed", 64'(cfg_if.cfg_ready), 64'(0));
    goto_pos(VD_P, 10'd0);
    step();
    chk("ready_commit", 64'(cfg_if.cfg_ready), 64'(0));
    chk("sy_not_written", 64'(scroll_y), 64'(0));
    step();
    chk("ready_reopen", 64'(cfg_if.cfg_ready), 64'(1));
    step();
    cfg_if.cfg_valid = 1'b0;
    chk("sy_still_old", 64'(scroll_y), 64'(0));
    arm();
    push_commit(10'd37, 10'd5, 4'd0, 4'd0, entry_frame());
    goto_pos(VD_P, 10'd0);
    step();
    chk("sy_committed", 64'(scroll_y), 64'(5));
    step();

    // write and commit_req in the same cycle
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_addr   = ADDR_MODE;
    cfg_if.cfg_data   = 10'd9;
    cfg_if.commit_req = 1'b1;
    step();
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.commit_req = 1'b0;
    chk("armed_with_write", 64'(armed), 64'(1));
    push_commit(10'd37, 10'd5, 4'd9, 4'd0, entry_frame());
    goto_pos(VD_P, 10'd0);
    chk("mode_before", 64'(mode), 64'(0));
    step();
    chk("mode_committed", 64'(mode), 64'(9));
    step();

    // commit_req on the entry sample itself waits one whole frame
    drive_write(ADDR_EFFECT, 10'h3F3);
    goto_pos(VD_P, 10'd0);
    cfg_if.commit_req = 1'b1;
    step();
    cfg_if.commit_req = 1'b0;
    chk("armed_missed_entry", 64'(armed), 64'(1));
    chk("effect_not_yet", 64'(effect), 64'(0));
    push_commit(10'd37, 10'd5, 4'd9, 4'd3, gen_frame + 1);
    goto_pos(VD_P, 10'd0);
    chk("effect_wait_frame", 64'(effect), 64'(0));
    chk("armed_wait_frame", 64'(armed), 64'(1));
    step();
    chk("effect_committed", 64'(effect), 64'(3));
    step();

    // out-of-range positions: no strobes, no commit
    arm();
    push_commit(10'd37, 10'd5, 4'd9, 4'd3, entry_frame());
    oor(10'd0, VM_P + 10'd1);
    oor(HM_P + 10'd1, 10'd0);
    oor(HM_P + 10'd1, VD_P);
    oor(10'h3FF, 10'h3FF);
    chk("armed_through_oor", 64'(armed), 64'(1));
    goto_pos(VD_P, 10'd0);
    step();
    step();

    // reset while ARMED drops the commit and clears shadow
    drive_write(ADDR_EFFECT, 10'd7);
    drive_write(ADDR_SCROLL_X, 10'd11);
    arm();
    goto_pos(10'd2, 10'd0);
    reset = 1'b1;
    exp_q.delete();
    fc_exp = '0;
    #1;
    chk("rst_armed", 64'(armed), 64'(0));
    chk("rst_outputs", 64'({scroll_x, scroll_y, mode, effect, frame_start, line_start,
                            vblank, frame_count}), 64'(0));
    chk("rst_ready", 64'(cfg_if.cfg_ready), 64'(1));
    chk("rst_state", 64'(dbg.state), 64'(ST_OPEN));
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    goto_pos(VD_P, 10'd0);
    step();
    chk("no_commit_after_rst", 64'(armed), 64'(0));
    chk("active_cleared", 64'({scroll_x, scroll_y, mode, effect}), 64'(0));
    step();
    drive_write(ADDR_SCROLL_X, 10'd1);
    arm();
    push_commit(10'd1, 10'd0, 4'd0, 4'd0, entry_frame());
    goto_pos(VD_P, 10'd0);
    step();
    chk("shadow_cleared_sx", 64'(scroll_x), 64'(1));
    chk("shadow_cleared_ef", 64'(effect), 64'(0));
    step();

    // 256 frames: frame_count wraps, line count per frame
    repeat (256 * FRAME) step();
    chk("frame_count_final", 64'(frame_count), 64'(fc_exp));

    @(negedge clk);
    #1;
    chk("commits_outstanding", 64'(cmt_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_frame_scheduler.md
VGA_FRAME_SCHEDULER -- requirements
Module: vga_frame_scheduler

Interface
REQ-001 Parameters SHALL be: H_DISPLAY, default 640, visible width; H_MAX, default 799, last hpos of a line; V_DISPLAY, default 480, visible height; V_MAX, default 524, last vpos of a frame.
REQ-002 clk  input  1  single clock; all state changes on posedge clk.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 hpos  input  10  horizontal beam position from the sync generator.
REQ-005 vpos  input  10  vertical beam position from the sync generator.
REQ-006 cfg_valid  input  1  config write request.
REQ-007 cfg_ready  output  1  config write accepted when high together with cfg_valid.
REQ-008 cfg_addr  input  2  shadow register select: 0 scroll_x, 1 scroll_y, 2 mode, 3 effect.
REQ-009 cfg_data  input  10  write data; mode and effect use bits [3:0] only.
REQ-010 commit_req  input  1  one-cycle pulse that arms a commit of the shadow set.
REQ-011 scroll_x, scroll_y  output  10 each  active (committed) scroll registers.
REQ-012 mode, effect  output  4 each  active (committed) control registers.
REQ-013 frame_start  output  1  one-cycle strobe per frame.
REQ-014 line_start  output  1  one-cycle strobe per line.
REQ-015 vblank  output  1  high while vpos >= V_DISPLAY.
REQ-016 frame_count  output  8  frames elapsed since reset.
REQ-017 armed  output  1  a commit is pending.

Function
REQ-018 All outputs SHALL be registered, with a latency of 1 cycle from the hpos/vpos sample that causes them.
REQ-019 line_start SHALL assert for 1 cycle after each sample with hpos==0; frame_start SHALL assert for 1 cycle after each sample with hpos==0 and vpos==0.
REQ-020 frame_count SHALL increment in the same cycle that frame_start asserts, and SHALL wrap from 255 to 0.
REQ-021 The FSM SHALL have three states: OPEN, ARMED and COMMIT, and SHALL reset to OPEN.
REQ-022 In OPEN: cfg_ready=1; each cfg_valid&cfg_ready cycle SHALL write cfg_data into the addressed shadow register; commit_req SHALL move the FSM to ARMED.
REQ-023 If cfg_valid and commit_req are both high in the same OPEN cycle, the write SHALL land in shadow and SHALL be included in the commit.
REQ-024 In ARMED and COMMIT: cfg_ready=0, so the shadow set is frozen; commit_req SHALL be ignored.
REQ-025 The FSM SHALL leave ARMED for COMMIT on the sample with vpos==V_DISPLAY and hpos==0 (the vblank entry event).
REQ-026 COMMIT SHALL last exactly 1 cycle, copy all four shadow registers to the active outputs atomically, and return to OPEN.
REQ-027 If commit_req arrives during the vblank-entry sample itself, that event SHALL be missed and the commit SHALL wait one full frame.
REQ-028 Active registers SHALL change only in COMMIT; they SHALL never change while vpos < V_DISPLAY.
REQ-029 hpos > H_MAX or vpos > V_MAX SHALL cause no strobes and no commit.
REQ-030 armed SHALL be 1 exactly when the FSM is in ARMED or COMMIT.

Reset
REQ-031 On reset assertion, the FSM SHALL go to OPEN, and all shadow, active registers, frame_count, strobes, vblank and armed SHALL go to 0, with cfg_ready=1.
REQ-032 A reset asserted while in ARMED SHALL drop the pending commit; the shadow contents SHALL be cleared, not committed.

Structure
REQ-033 Timing constants, the FSM state enum and the cfg_addr encodings SHALL live in the shared package vga_pkg.
REQ-034 The shadow/active register pair SHALL be a sub-module named vga_cfg_regs, instantiated once; the FSM and strobes SHALL stay in the top level.

Verification
REQ-035 Write scroll_x=37, then commit_req at vpos=100 -> scroll_x stays 0 until the cycle after vpos=480,hpos=0, then reads 37; armed drops 1 cycle later.
REQ-036 cfg_valid with addr=1, data=5 held high during ARMED -> cfg_ready=0, no write; after COMMIT the write is accepted, and scroll_y=5 appears only after the next commit.
REQ-037 cfg_valid (addr 2, data 9) and commit_req in the same cycle -> mode=9 after the next vblank entry.
REQ-038 commit_req coincident with vpos=480,hpos=0 -> commit occurs one frame later (420,000 cycles at default parameters).
REQ-039 Run 256 frames -> frame_count wraps to 0; exactly 525 line_start pulses per frame_start.
REQ-040 Assert reset while ARMED -> armed=0 and all outputs 0 immediately, with no commit at the next vblank.
